// File: rtl/ptmu_mm.sv
// Multi-modulation payload tone map unit: packs the serial payload stream into
// 1/2/4/6-bit sub-carrier groups with ready/valid output and zero-pad flush.
module ptmu_mm #(
    parameter int unsigned MAX_BITS = 6,
    parameter int unsigned SC_NUM   = 224,
    parameter int unsigned SC_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mod_sel,
    input  logic                di,
    input  logic                di_vld,
    output logic                di_rdy,
    input  logic                flush,
    // "do" is a reserved word, so the grouped-bit output is do_data
    output logic [MAX_BITS-1:0] do_data,
    output logic                do_vld,
    input  logic                do_rdy,
    output logic [SC_W-1:0]     do_sc_idx,
    output logic                do_sym_end,
    output logic                busy
);

    localparam int unsigned CW = $clog2(MAX_BITS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PAD     = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [MAX_BITS-1:0] sr;
    logic [CW-1:0]       bit_cnt;
    logic [SC_W-1:0]     sc_cnt;
    logic [CW-1:0]       g_lat;

    logic                slot_free;
    logic                acc;
    logic                sym_start;
    logic [CW-1:0]       g_eff;
    logic                grp_done;
    logic                last_sc;
    logic                pad_emit;
    logic                emit;
    logic                flush_go;
    logic [MAX_BITS-1:0] sr_next;

    function automatic logic [CW-1:0] grp_size(input logic [1:0] sel);
        case (sel)
            2'd0:    return CW'(1);
            2'd1:    return CW'(2);
            2'd2:    return CW'(4);
            default: return CW'(6);
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (flush_go)                          state_nxt = PAD;
                else if (acc && !(grp_done && last_sc)) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (flush_go)                 state_nxt = PAD;
                else if (grp_done && last_sc) state_nxt = IDLE;
            end
            PAD: begin
                if (pad_emit && last_sc) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and emission decode; group size is taken live from mod_sel on
    // the first bit of a symbol so a 1-bit group can complete immediately
    always_comb begin
        busy      = (bit_cnt != '0) || (sc_cnt != '0) || (state == PAD);
        slot_free = !do_vld || do_rdy;
        di_rdy    = (state != PAD) && slot_free;
        acc       = di_vld && di_rdy;
        sym_start = (sc_cnt == '0) && (bit_cnt == '0);
        g_eff     = sym_start ? grp_size(mod_sel) : g_lat;
        grp_done  = acc && (bit_cnt == g_eff - CW'(1));
        last_sc   = (sc_cnt == SC_W'(SC_NUM - 1));
        pad_emit  = (state == PAD) && slot_free;
        emit      = grp_done || pad_emit;
        sr_next   = sr | (MAX_BITS'(di) << bit_cnt);
        // a flush that lands with the symbol's final group has nothing to pad
        flush_go  = flush && busy && (state != PAD) && !(grp_done && last_sc);
    end

    // Datapath: shift register, counters and the single-entry output slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            bit_cnt    <= '0;
            sc_cnt     <= '0;
            g_lat      <= '0;
            do_data    <= '0;
            do_vld     <= 1'b0;
            do_sc_idx  <= '0;
            do_sym_end <= 1'b0;
        end else begin
            if (acc && sym_start) g_lat <= grp_size(mod_sel);
            if (emit) begin
                do_data    <= grp_done ? sr_next : sr;
                do_vld     <= 1'b1;
                do_sc_idx  <= sc_cnt;
                do_sym_end <= last_sc;
                sr         <= '0;
                bit_cnt    <= '0;
                sc_cnt     <= last_sc ? '0 : sc_cnt + SC_W'(1);
            end else begin
                if (do_rdy) do_vld <= 1'b0;
                if (acc) begin
                    sr      <= sr_next;
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ptmu_mm.sv
// Directed self-checking bench for ptmu_mm with a 4-sub-carrier symbol.
module tb_ptmu_mm;

    localparam int unsigned MAX_BITS = 6;
    localparam int unsigned SC_NUM   = 4;
    localparam int unsigned SC_W     = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          mod_sel;
    logic                di;
    logic                di_vld;
    logic                di_rdy;
    logic                flush;
    logic [MAX_BITS-1:0] do_data;
    logic                do_vld;
    logic                do_rdy;
    logic [SC_W-1:0]     do_sc_idx;
    logic                do_sym_end;
    logic                busy;

    int n_chk  = 0;
    int n_fail = 0;
    logic [14:0] grp_q[$];

    ptmu_mm #(.MAX_BITS(MAX_BITS), .SC_NUM(SC_NUM), .SC_W(SC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mod_sel    (mod_sel),
        .di         (di),
        .di_vld     (di_vld),
        .di_rdy     (di_rdy),
        .flush      (flush),
        .do_data    (do_data),
        .do_vld     (do_vld),
        .do_rdy     (do_rdy),
        .do_sc_idx  (do_sc_idx),
        .do_sym_end (do_sym_end),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Record every accepted output group as {sym_end, idx, data}
    always @(negedge clk) begin
        if (!rst && do_vld && do_rdy) grp_q.push_back({do_sym_end, do_sc_idx, do_data});
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        int guard;
        guard  = 0;
        di     = b;
        di_vld = 1'b1;
        #1;
        while (!di_rdy && guard < 20) begin
            tick();
            #1;
            guard++;
        end
        if (guard >= 20) chk_eq("send_timeout", 32'(di_rdy), 32'd1);
        tick();
        di_vld = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) send_bit(bits[i]);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic exp_grp(input string tag, input logic [5:0] d, input logic [7:0] idx, input logic e);
        logic [14:0] got;
        got = '1;
        if (grp_q.size() != 0) got = grp_q.pop_front();
        chk_eq(tag, 32'(got), 32'({e, idx, d}));
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) tick();
    endtask

    initial begin
        logic [7:0]  q_bits;
        logic [1:0]  q_exp [4];
        q_bits = 8'b0011_1001;  // LSB-first stream 1,0,0,1,1,1,0,0
        q_exp  = '{2'h1, 2'h2, 2'h3, 2'h0};

        rst = 1'b1; mod_sel = 2'd0; di = 1'b0; di_vld = 1'b0; flush = 1'b0; do_rdy = 1'b1;
        tick(); tick();
        chk_eq("rst_do_vld", 32'(do_vld), 32'd0);
        chk_eq("rst_do_data", 32'(do_data), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_sc_idx", 32'(do_sc_idx), 32'd0);
        rst = 1'b0;
        tick();

        // QPSK continuous stream with per-group latency checks
        mod_sel = 2'd1;
        for (int i = 0; i < 8; i++) begin
            send_bit(q_bits[i]);
            if (i % 2 == 1) begin
                chk_eq("qpsk_vld", 32'(do_vld), 32'd1);
                chk_eq("qpsk_data", 32'(do_data), 32'(q_exp[i/2]));
                chk_eq("qpsk_idx", 32'(do_sc_idx), 32'(i/2));
                chk_eq("qpsk_end", 32'(do_sym_end), 32'(i == 7));
            end else begin
                chk_eq("qpsk_gap_vld", 32'(do_vld), 32'd0);
            end
        end
        tick();
        chk_eq("qpsk_busy_after", 32'(busy), 32'd0);
        grp_q.delete();

        // 16QAM symbol with a mid-symbol mod_sel change, then a 64QAM symbol
        mod_sel = 2'd2;
        send_bits(32'b11, 2);
        mod_sel = 2'd3;
        send_bits(32'b10, 2);
        send_bits(32'd0, 12);
        send_bits(32'b110101, 6);
        do_flush();
        drain();
        exp_grp("qam16_g0", 6'hB, 8'd0, 1'b0);
        exp_grp("qam16_g1", 6'h0, 8'd1, 1'b0);
        exp_grp("qam16_g2", 6'h0, 8'd2, 1'b0);
        exp_grp("qam16_g3", 6'h0, 8'd3, 1'b1);
        exp_grp("qam64_g0", 6'h35, 8'd0, 1'b0);
        exp_grp("qam64_pad1", 6'h0, 8'd1, 1'b0);
        exp_grp("qam64_pad2", 6'h0, 8'd2, 1'b0);
        exp_grp("qam64_pad3", 6'h0, 8'd3, 1'b1);
        chk_eq("qam_q_empty", 32'(grp_q.size()), 32'd0);

        // BPSK with 5 cycles of output backpressure
        mod_sel = 2'd0;
        do_rdy  = 1'b0;
        send_bit(1'b1);
        di = 1'b0; di_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_eq("bp_di_rdy", 32'(di_rdy), 32'd0);
            chk_eq("bp_hold", 32'({do_vld, do_sc_idx, do_data}), 32'({1'b1, 8'd0, 6'h1}));
            tick();
        end
        do_rdy = 1'b1;
        #1;
        chk_eq("bp_release_rdy", 32'(di_rdy), 32'd1);
        tick();
        di_vld = 1'b0;
        send_bits(32'b11, 2);
        drain();
        exp_grp("bp_g0", 6'h1, 8'd0, 1'b0);
        exp_grp("bp_g1", 6'h0, 8'd1, 1'b0);
        exp_grp("bp_g2", 6'h1, 8'd2, 1'b0);
        exp_grp("bp_g3", 6'h1, 8'd3, 1'b1);

        // Flush mid-group in 16QAM after 1,1,1,1,1,0
        mod_sel = 2'd2;
        send_bits(32'b011111, 6);
        do_flush();
        di_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_eq("pad_di_rdy", 32'(di_rdy), 32'd0);
            chk_eq("pad_busy", 32'(busy), 32'd1);
            tick();
        end
        di_vld = 1'b0;
        tick();
        chk_eq("pad_busy_fall", 32'(busy), 32'd0);
        drain();
        exp_grp("fl_g0", 6'hF, 8'd0, 1'b0);
        exp_grp("fl_g1", 6'h1, 8'd1, 1'b0);
        exp_grp("fl_g2", 6'h0, 8'd2, 1'b0);
        exp_grp("fl_g3", 6'h0, 8'd3, 1'b1);

        // Flush while idle is ignored
        do_flush();
        drain();
        chk_eq("idle_flush_q", 32'(grp_q.size()), 32'd0);
        chk_eq("idle_flush_busy", 32'(busy), 32'd0);

        // Flush coincident with the final group of a BPSK symbol
        mod_sel = 2'd0;
        send_bits(32'b101, 3);
        flush = 1'b1;
        send_bit(1'b1);
        flush = 1'b0;
        drain();
        chk_eq("coinc_q_size", 32'(grp_q.size()), 32'd4);
        exp_grp("coinc_g0", 6'h1, 8'd0, 1'b0);
        exp_grp("coinc_g1", 6'h0, 8'd1, 1'b0);
        exp_grp("coinc_g2", 6'h1, 8'd2, 1'b0);
        exp_grp("coinc_g3", 6'h1, 8'd3, 1'b1);
        chk_eq("coinc_busy", 32'(busy), 32'd0);

        // Reset mid-group
        mod_sel = 2'd2;
        send_bits(32'b11, 2);
        rst = 1'b1;
        #1;
        chk_eq("rst_mid_busy", 32'(busy), 32'd0);
        chk_eq("rst_mid_vld", 32'(do_vld), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Reset mid-PAD with a stalled partial group in the output slot
        send_bits(32'b011111, 6);
        do_rdy = 1'b0;
        do_flush();
        tick();
        chk_eq("pre_rst_vld", 32'(do_vld), 32'd1);
        rst = 1'b1;
        #1;
        chk_eq("rst_pad_out", 32'({do_vld, do_sym_end, do_sc_idx, do_data}), 32'd0);
        chk_eq("rst_pad_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        do_rdy = 1'b1;
        exp_grp("rst_pad_prev", 6'hF, 8'd0, 1'b0);
        chk_eq("rst_pad_q", 32'(grp_q.size()), 32'd0);
        tick();

        // Fresh QPSK symbol after reset
        mod_sel = 2'd1;
        send_bits(32'b01, 2);
        chk_eq("post_rst_grp", 32'({do_vld, do_sym_end, do_sc_idx, do_data}), 32'({1'b1, 1'b0, 8'd0, 6'h1}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ptmu_mm.md
Name: ptmu_mm

Overview:
- Multi-modulation payload tone map unit; successor to the fixed-16QAM payload tone mapper.
- Takes the serial channel-encoded payload bit stream and groups bits per sub-carrier. Group size is selected at runtime: BPSK 1, QPSK 2, 16QAM 4, 64QAM 6 bits.
- Adds a ready/valid output handshake with input backpressure, a sub-carrier index output, and a flush that zero-pads the current OFDM symbol to its end.
- Sits between channel encoder and constellation mapper/scrambler.

Parameters:
- MAX_BITS, 6, width of do; largest group size supported.
- SC_NUM, 224, data sub-carriers per OFDM symbol; must be ≥2.
- SC_W, 8, width of do_sc_idx; must satisfy 2^SC_W ≥ SC_NUM.

Ports:
- clk  in  1  working clock
- rst  in  1  reset
- mod_sel  in  2  0=BPSK, 1=QPSK, 2=16QAM, 3=64QAM
- di  in  1  serial payload bit
- di_vld  in  1  di valid
- di_rdy  out  1  block accepts di this cycle
- flush  in  1  pulse: pad current symbol with zeros to its end
- do  out  MAX_BITS  grouped bits, right-justified
- do_vld  out  1  do valid
- do_rdy  in  1  downstream accepts do
- do_sc_idx  out  SC_W  sub-carrier index of do, 0..SC_NUM-1
- do_sym_end  out  1  do is last sub-carrier of symbol
- busy  out  1  symbol in progress (bit_cnt≠0 or sc_cnt≠0 or PAD)

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs reset to 0, state IDLE, counters 0, shift register 0.
- Group size G = 1/2/4/6 from mod_sel.
  - mod_sel is latched at the first accepted bit of each symbol (sc_cnt==0 && bit_cnt==0).
  - Changes of mod_sel mid-symbol are ignored until the next symbol.
- Bit accept: a bit is accepted when di_vld && di_rdy.
- Output register handshake: single-entry.
  - do_vld holds, with do/do_sc_idx/do_sym_end stable, until do_rdy.
  - di_rdy = (state != PAD) && !(do_vld && !do_rdy), combinational.
- Packing:
  - The k-th accepted bit of a group (k=0..G-1) goes to do[k]; first bit lands in the LSB.
  - do[MAX_BITS-1:G] = 0.
  - The shift register clears after each emitted group.
- Latency: accepting bit G-1 of a group at edge t gives do_vld=1 after edge t (visible in cycle t+1). Full throughput: one bit per cycle with do_rdy held 1.
- Counters:
  - bit_cnt increments on each accept and wraps at G-1.
  - sc_cnt increments on each group emission and wraps at SC_NUM-1 → 0.
  - do_sc_idx = sc_cnt value of the emitted group.
  - do_sym_end = 1 iff do_sc_idx == SC_NUM-1.
  - di_vld low does NOT reset bit_cnt; gaps in input are allowed mid-group.
- FSM:
  - IDLE→COLLECT on first accept.
  - COLLECT→IDLE on emission of a sym_end group.
  - COLLECT/IDLE→PAD on flush when busy.
  - PAD→IDLE after emitting the sym_end group.
- Flush / PAD:
  - In PAD, di_rdy=0.
  - A partial group (bit_cnt>0) is emitted with the missing bits = 0 on the first free output slot.
  - Then all-zero groups are emitted, one per output slot, for the remaining sub-carriers; last one has do_sym_end=1.
  - flush when !busy: ignored.
  - flush in PAD: ignored.
  - flush in the same cycle as the accept that completes the last group of a symbol: the flush is ignored (symbol already complete).
- Simultaneous event: an accept and a flush in the same cycle mid-symbol → the bit is accepted first, then padding starts from the updated bit_cnt.
- Reset mid-symbol: everything clears immediately; no sym_end is emitted.

Test Plan:
- QPSK, SC_NUM=4, bits 1,0,0,1,1,1,0,0 continuous, do_rdy=1 → do = 0x1, 0x2, 0x3, 0x0; do_sc_idx 0..3; do_sym_end only on the 4th; each do_vld 1 cycle after the 2nd bit of its group.
- 16QAM bits 1,1,0,1 then 64QAM next symbol bits 1,0,1,0,1,1 → do = 0xB then 0x35. A mod_sel change mid-symbol has no effect until the next symbol.
- Backpressure: do_rdy=0 for 5 cycles while bits are offered in BPSK → di_rdy=0 after the first group; do held stable; no bit lost; sequence intact after do_rdy=1.
- Flush in 16QAM, SC_NUM=4, after 6 bits (1,1,1,1,1,0) → groups 0xF, 0x1, 0x0, 0x0 at idx 0..3; sym_end on idx 3; di_rdy=0 throughout PAD; busy falls after.
- flush with busy=0 → no output. flush coincident with completion of the last group → exactly SC_NUM groups, no extra padding.
- rst asserted mid-group and mid-PAD → all outputs 0 immediately; the next symbol starts at idx 0 with correct packing.
